// File: rtl/bonsai_sched_pkg.sv
// Shared types and widths for the leaf refill scheduler and its helpers.
package bonsai_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_t;

   localparam int BURST_IDX_W        = 16;
   localparam int DEFAULT_LEAF_DEPTH = 16;
   localparam int CREDIT_W           = $clog2(DEFAULT_LEAF_DEPTH + 1);

   // Credit counters must hold the value LEAF_DEPTH itself, hence depth+1.
   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester at or after i_ptr,
// wrapping to index 0.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   logic [N-1:0] w_req_hi;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_mask
         assign w_req_hi[gi] = i_req[gi] && (IDX_W'(gi) >= i_ptr);
      end
   endgenerate

   // Lowest requester overall is the wrap-around fallback; lowest one at or
   // above the pointer overrides it when present.
   always_comb begin
      o_idx   = '0;
      o_grant = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) o_idx = IDX_W'(i);
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (w_req_hi[i]) o_idx = IDX_W'(i);
      end
      o_valid = |i_req;
      if (o_valid) o_grant[o_idx] = 1'b1;
   end

endmodule

// File: rtl/leaf_refill_scheduler.sv
// Credit-based refill scheduler: issues burst reads to leaf FIFOs of a merge
// tree in round-robin order, bounded by leaf space and outstanding requests.
module leaf_refill_scheduler
   import bonsai_sched_pkg::*;
#(
   parameter int NUM_LEAVES      = 128,
   parameter int LEAF_DEPTH      = 16,
   parameter int BURST           = 8,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_start,
   input  logic [BURST_IDX_W-1:0]         i_run_bursts,
   input  logic [NUM_LEAVES-1:0]          i_leaf_deq,
   input  logic                           i_req_ready,
   input  logic                           i_resp_done,
   output logic                           o_req_valid,
   output logic [$clog2(NUM_LEAVES)-1:0]  o_req_leaf,
   output logic [BURST_IDX_W-1:0]         o_req_burst,
   output logic                           o_busy,
   output logic                           o_done,
   output logic                           o_err
);

   localparam int LEAF_W = $clog2(NUM_LEAVES);
   localparam int CW     = credit_width(LEAF_DEPTH);
   localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [CW-1:0]     C_FULL    = CW'(LEAF_DEPTH);
   localparam logic [CW-1:0]     C_BURST   = CW'(BURST);
   localparam logic [OUT_W-1:0]  OUT_MAX   = OUT_W'(MAX_OUTSTANDING);
   localparam logic [LEAF_W-1:0] LAST_LEAF = LEAF_W'(NUM_LEAVES - 1);

   sched_state_t           r_state;
   logic [BURST_IDX_W-1:0] r_run_bursts;
   logic [OUT_W-1:0]       r_outstanding;
   logic [LEAF_W-1:0]      r_rr_ptr;
   logic                   r_req_valid;
   logic [LEAF_W-1:0]      r_req_leaf;
   logic [BURST_IDX_W-1:0] r_req_burst;
   logic                   r_done;
   logic                   r_err;

   logic [CW-1:0]          w_credit    [NUM_LEAVES];
   logic [BURST_IDX_W-1:0] w_burst_idx [NUM_LEAVES];
   logic [NUM_LEAVES-1:0]  w_eligible;
   logic [NUM_LEAVES-1:0]  w_leaf_done;
   logic [NUM_LEAVES-1:0]  w_ovf;
   logic [NUM_LEAVES-1:0]  w_grant;
   logic [LEAF_W-1:0]      w_win_idx;
   logic [LEAF_W-1:0]      w_ptr_next;
   logic                   w_any_elig;
   logic                   w_active;
   logic                   w_slot_free;
   logic                   w_sel;
   logic                   w_all_done;
   logic                   w_req_clear;
   logic                   w_resp_ok;
   logic                   w_resp_bad;

   assign w_active    = (r_state != ST_IDLE);
   assign w_req_clear = !r_req_valid || i_req_ready;
   assign w_slot_free = (r_outstanding < OUT_MAX) && w_req_clear;
   assign w_sel       = (r_state == ST_RUN) && w_slot_free && w_any_elig;
   assign w_all_done  = &w_leaf_done;
   assign w_resp_ok   = i_resp_done && (r_outstanding != '0);
   assign w_resp_bad  = i_resp_done && (r_outstanding == '0);
   assign w_ptr_next  = (w_win_idx == LAST_LEAF) ? '0 : w_win_idx + LEAF_W'(1);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LEAVES; gi++) begin : g_leaf
         logic [CW-1:0]          r_credit;
         logic [BURST_IDX_W-1:0] r_burst_idx;
         logic                   w_picked;

         assign w_picked         = w_sel && w_grant[gi];
         assign w_credit[gi]     = r_credit;
         assign w_burst_idx[gi]  = r_burst_idx;
         assign w_eligible[gi]   = (r_state == ST_RUN) && (r_credit >= C_BURST) &&
                                   (r_burst_idx < r_run_bursts);
         assign w_leaf_done[gi]  = (r_burst_idx == r_run_bursts);
         // A dequeue is only an overflow if this leaf is not simultaneously
         // being charged a burst.
         assign w_ovf[gi]        = w_active && i_leaf_deq[gi] && !w_picked &&
                                   (r_credit == C_FULL);

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_credit    <= '0;
               r_burst_idx <= '0;
            end else if (r_state == ST_IDLE) begin
               if (i_start) begin
                  r_credit    <= C_FULL;
                  r_burst_idx <= '0;
               end
            end else if (w_picked) begin
               r_credit    <= r_credit - C_BURST + CW'(i_leaf_deq[gi]);
               r_burst_idx <= r_burst_idx + BURST_IDX_W'(1);
            end else if (i_leaf_deq[gi] && (r_credit != C_FULL)) begin
               r_credit <= r_credit + CW'(1);
            end
         end
      end
   endgenerate

   rr_arbiter #(
      .N     (NUM_LEAVES),
      .IDX_W (LEAF_W)
   ) u_rr_arbiter (
      .i_req   (w_eligible),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_win_idx),
      .o_valid (w_any_elig)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_run_bursts  <= '0;
         r_outstanding <= '0;
         r_rr_ptr      <= '0;
         r_req_valid   <= 1'b0;
         r_req_leaf    <= '0;
         r_req_burst   <= '0;
         r_done        <= 1'b0;
         r_err         <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         r_done <= 1'b0;
         if (i_start) begin
            r_run_bursts  <= i_run_bursts;
            r_outstanding <= '0;
            r_rr_ptr      <= '0;
            r_err         <= 1'b0;
            r_state       <= (i_run_bursts == '0) ? ST_DRAIN : ST_RUN;
         end
      end else begin
         if (w_sel) begin
            r_req_valid <= 1'b1;
            r_req_leaf  <= w_win_idx;
            r_req_burst <= w_burst_idx[w_win_idx];
            r_rr_ptr    <= w_ptr_next;
         end else if (r_req_valid && i_req_ready) begin
            r_req_valid <= 1'b0;
         end

         // An issue and a completion in the same cycle cancel out.
         case ({w_sel, w_resp_ok})
            2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase

         if ((|w_ovf) || w_resp_bad) r_err <= 1'b1;

         case (r_state)
            ST_RUN: begin
               if (w_all_done && w_req_clear) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (r_outstanding == '0) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_req_valid = r_req_valid;
   assign o_req_leaf  = r_req_leaf;
   assign o_req_burst = r_req_burst;
   assign o_busy      = w_active;
   assign o_done      = r_done;
   assign o_err       = r_err;

endmodule

// File: tb/tb_leaf_refill_scheduler.sv
// Randomized scoreboard bench for leaf_refill_scheduler (4 leaves, depth 16,
// burst 8, 4 outstanding) against a behavioural model of the scheduling rules.
module tb_leaf_refill_scheduler;

   localparam int N     = 4;
   localparam int DEPTH = 16;
   localparam int BURST = 8;
   localparam int MAXO  = 4;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DONE  = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_start = 1'b0;
   logic [15:0] i_run_bursts = '0;
   logic [N-1:0] i_leaf_deq = '0;
   logic        i_req_ready = 1'b0;
   logic        i_resp_done = 1'b0;
   logic        o_req_valid;
   logic [1:0]  o_req_leaf;
   logic [15:0] o_req_burst;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   leaf_refill_scheduler #(
      .NUM_LEAVES      (N),
      .LEAF_DEPTH      (DEPTH),
      .BURST           (BURST),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (i_start),
      .i_run_bursts (i_run_bursts),
      .i_leaf_deq   (i_leaf_deq),
      .i_req_ready  (i_req_ready),
      .i_resp_done  (i_resp_done),
      .o_req_valid  (o_req_valid),
      .o_req_leaf   (o_req_leaf),
      .o_req_burst  (o_req_burst),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_err        (o_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: leaf space, bursts handed out, requests in flight.
   int m_state = M_IDLE;
   int m_credit [N];
   int m_issued [N];
   int m_out = 0;
   int m_ptr = 0;
   int m_rb  = 0;
   bit m_pend = 0;
   bit m_done = 0;
   bit m_err  = 0;
   int q_leaf [$];
   int q_burst [$];

   int acc_cnt  = 0;
   int acc_base = 0;
   int pass_rb  = 0;
   bit mon_en   = 0;

   function automatic void check(string nm, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_state = M_IDLE;
      for (int l = 0; l < N; l++) begin
         m_credit[l] = 0;
         m_issued[l] = 0;
      end
      m_out = 0; m_ptr = 0; m_rb = 0;
      m_pend = 0; m_done = 0; m_err = 0;
      q_leaf.delete();
      q_burst.delete();
   endfunction

   function automatic void model_step(bit st, int rb, logic [N-1:0] deq, bit rdy, bit resp);
      int  win;
      int  issued_sum;
      int  out_old;
      int  l;
      bit  pend_old;
      if (m_state == M_IDLE) begin
         m_done = 0;
         if (st) begin
            for (int k = 0; k < N; k++) begin
               m_credit[k] = DEPTH;
               m_issued[k] = 0;
            end
            m_out = 0; m_ptr = 0; m_rb = rb; m_err = 0; m_pend = 0;
            m_state = (rb == 0) ? M_DRAIN : M_RUN;
         end
         return;
      end
      pend_old   = m_pend;
      out_old    = m_out;
      win        = -1;
      issued_sum = 0;
      for (int k = 0; k < N; k++) issued_sum += m_issued[k];
      if (m_state == M_RUN && out_old < MAXO && (!pend_old || rdy)) begin
         for (int k = 0; k < N; k++) begin
            l = (m_ptr + k) % N;
            if (win < 0 && m_credit[l] >= BURST && m_issued[l] < m_rb) win = l;
         end
      end
      for (int k = 0; k < N; k++) begin
         if (k == win) m_credit[k] = m_credit[k] - BURST + int'(deq[k]);
         else if (deq[k]) begin
            if (m_credit[k] == DEPTH) m_err = 1;
            else m_credit[k]++;
         end
      end
      if (win >= 0) begin
         q_leaf.push_back(win);
         q_burst.push_back(m_issued[win]);
         m_issued[win]++;
         m_ptr  = (win + 1) % N;
         m_pend = 1;
      end else if (pend_old && rdy) begin
         m_pend = 0;
      end
      if (resp) begin
         if (out_old == 0) m_err = 1;
         else m_out--;
      end
      if (win >= 0) m_out++;
      case (m_state)
         M_RUN:   if (issued_sum == N * m_rb && (!pend_old || rdy)) m_state = M_DRAIN;
         M_DRAIN: if (out_old == 0) begin m_state = M_DONE; m_done = 1; end
         default: begin m_done = 0; m_state = M_IDLE; end
      endcase
   endfunction

   // Monitor: samples late in the low phase, just before the active edge.
   always begin
      @(negedge clk);
      #3;
      if (mon_en) begin
         check("req_valid", int'(o_req_valid), int'(m_pend));
         check("busy", int'(o_busy), int'(m_state != M_IDLE));
         check("done", int'(o_done), int'(m_done));
         check("err", int'(o_err), int'(m_err));
         if (o_req_valid && q_leaf.size() > 0) begin
            check("req_leaf", int'(o_req_leaf), q_leaf[0]);
            check("req_burst", int'(o_req_burst), q_burst[0]);
            if (i_req_ready) begin
               $display("[TB] accept leaf=%0d burst=%0d t=%0t", o_req_leaf, o_req_burst, $time);
               void'(q_leaf.pop_front());
               void'(q_burst.pop_front());
               acc_cnt++;
            end
         end
      end
   end

   task automatic drive_cycle(input bit st, input logic [15:0] rb, input logic [N-1:0] deq,
                              input bit rdy, input bit resp);
      @(negedge clk);
      i_start      = st;
      i_run_bursts = rb;
      i_leaf_deq   = deq;
      i_req_ready  = rdy;
      i_resp_done  = resp;
      @(posedge clk);
      #1;
      model_step(st, int'(rb), deq, rdy, resp);
   endtask

   task automatic rand_cycle(input int ready_pct, input bit faults);
      logic [N-1:0] d;
      bit rdy, rs, st;
      for (int l = 0; l < N; l++) begin
         d[l] = ((m_credit[l] < DEPTH) && ($urandom_range(99) < 30)) ||
                (faults && ($urandom_range(99) < 3));
      end
      rs  = ((m_out > 0) && ($urandom_range(99) < 40)) ||
            (faults && (m_out == 0) && ($urandom_range(99) < 5));
      rdy = ($urandom_range(99) < ready_pct);
      st  = ($urandom_range(99) < 4);
      drive_cycle(st, 16'($urandom), d, rdy, rs);
   endtask

   task automatic start_pass(input int rb);
      pass_rb  = rb;
      acc_base = acc_cnt;
      $display("[TB] start pass run_bursts=%0d", rb);
      drive_cycle(1'b1, 16'(rb), '0, 1'b1, 1'b0);
   endtask

   task automatic finish_pass(input int ready_pct, input bit faults);
      int guard = 0;
      while (m_state != M_IDLE && guard < 3000) begin
         rand_cycle(ready_pct, faults);
         guard++;
      end
      check("pass_timeout", int'(guard >= 3000), 0);
      check("pass_req_count", acc_cnt - acc_base, N * pass_rb);
      check("pass_queue_empty", q_leaf.size(), 0);
   endtask

   initial begin
      model_reset();
      rst = 1'b1;
      mon_en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) drive_cycle(1'b0, 16'd0, '0, 1'b1, 1'b0);

      // Four leaves get one burst each, then the outstanding limit stalls.
      start_pass(2);
      repeat (10) drive_cycle(1'b0, 16'd0, '0, 1'b1, 1'b0);
      check("stall_at_max_out", acc_cnt - acc_base, 4);
      drive_cycle(1'b0, 16'd0, '0, 1'b1, 1'b1);
      repeat (3) drive_cycle(1'b0, 16'd0, '0, 1'b1, 1'b0);
      check("issue_after_resp", acc_cnt - acc_base, 5);
      finish_pass(100, 1'b0);

      // Back-pressure: request must hold while ready is low.
      start_pass(2);
      repeat (8) drive_cycle(1'b0, 16'd0, '0, 1'b0, 1'b0);
      check("no_accept_while_not_ready", acc_cnt - acc_base, 0);
      finish_pass(60, 1'b0);

      // Credit exhaustion: each leaf stops after two bursts until refilled.
      start_pass(3);
      repeat (30) drive_cycle(1'b0, 16'd0, '0, 1'b1, m_out > 0);
      check("credit_stall", acc_cnt - acc_base, 8);
      repeat (8) drive_cycle(1'b0, 16'd0, 4'b0001, 1'b1, m_out > 0);
      repeat (4) drive_cycle(1'b0, 16'd0, '0, 1'b1, 1'b0);
      check("refill_issue", acc_cnt - acc_base, 9);
      finish_pass(100, 1'b0);

      // Single-burst pass through to done.
      start_pass(1);
      finish_pass(100, 1'b0);

      // Dequeue on a full leaf flags overflow for the rest of the pass.
      start_pass(2);
      drive_cycle(1'b0, 16'd0, 4'b0100, 1'b1, 1'b0);
      finish_pass(70, 1'b0);

      start_pass(0);
      finish_pass(100, 1'b0);

      for (int p = 0; p < 12; p++) begin
         start_pass(int'($urandom_range(4)));
         finish_pass(int'($urandom_range(30, 100)), 1'b1);
      end

      // Asynchronous reset in the middle of a pass with a request pending.
      start_pass(3);
      begin
         int guard = 0;
         while (!m_pend && guard < 20) begin
            drive_cycle(1'b0, 16'd0, '0, 1'b0, 1'b0);
            guard++;
         end
      end
      check("pend_before_reset", int'(o_req_valid), 1);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_valid", int'(o_req_valid), 0);
      check("async_rst_busy", int'(o_busy), 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) drive_cycle(1'b0, 16'd2, 4'b1111, 1'b1, 1'b1);

      start_pass(2);
      finish_pass(80, 1'b0);

      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
